// File: rtl/ctrl_pkg.sv
// Shared control encodings for the 16-bit datapath: sequencer states,
// opcode/funct/branch-condition constants and the select/ALU encodings
// consumed by the datapath muxes and the ALU.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_LDWB   = 3'd4
  } state_e;

  // Opcode field ir[15:12]; 9..15 are undefined
  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_SUBI  = 4'd2;
  localparam logic [3:0] OP_CMPI  = 4'd3;
  localparam logic [3:0] OP_MOVI  = 4'd4;
  localparam logic [3:0] OP_LOAD  = 4'd5;
  localparam logic [3:0] OP_STOR  = 4'd6;
  localparam logic [3:0] OP_BCC   = 4'd7;
  localparam logic [3:0] OP_JAL   = 4'd8;

  // R-type funct field ir[2:0]; 7 is undefined
  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_AND = 3'd2;
  localparam logic [2:0] F_OR  = 3'd3;
  localparam logic [2:0] F_XOR = 3'd4;
  localparam logic [2:0] F_CMP = 3'd5;
  localparam logic [2:0] F_MOV = 3'd6;

  // Branch condition field ir[11:9]
  localparam logic [2:0] C_EQ = 3'd0;
  localparam logic [2:0] C_NE = 3'd1;
  localparam logic [2:0] C_LT = 3'd2;
  localparam logic [2:0] C_GE = 3'd3;
  localparam logic [2:0] C_CS = 3'd4;
  localparam logic [2:0] C_CC = 3'd5;
  localparam logic [2:0] C_AL = 3'd6;
  localparam logic [2:0] C_NV = 3'd7;

  typedef enum logic [1:0] {
    WR_ALU = 2'd0,
    WR_MEM = 2'd1,
    WR_IMM = 2'd2,
    WR_PC1 = 2'd3
  } wr_sel_e;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_REL = 2'd1,
    PC_REG = 2'd2
  } pc_sel_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_MOVB = 3'd5
  } alu_op_e;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator.
//   cond_i  : condition code ir[11:9]
//   flags_i : {n, z, c} from the flag register
//   taken_o : 1 when the branch is taken
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       taken_o
);

  logic n, z, c;
  assign {n, z, c} = flags_i;

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      C_EQ:    taken_o = z;
      C_NE:    taken_o = ~z;
      C_LT:    taken_o = n;
      C_GE:    taken_o = ~n;
      C_CS:    taken_o = c;
      C_CC:    taken_o = ~c;
      C_AL:    taken_o = 1'b1;
      C_NV:    taken_o = 1'b0;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC | MEM [-> LDWB].
// Inputs : clk, reset (async, active-high), instr (RAM read data),
//          flags {n,z,c}.
// Outputs: RF addresses/write enable/write select, ALU op and B select,
//          sign-extended imm, flag load, PC load/select, data-memory
//          address select and write, latched ir, illegal pulse, debug state.
// All outputs are Moore functions of state and ir (plus flags for a Bcc in EXEC).
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic [2:0]            flags,
  output logic [REG_ADDR_W-1:0] rf_addr1,
  output logic [REG_ADDR_W-1:0] rf_addr2,
  output logic                  rf_wr_en,
  output logic [1:0]            rf_wr_sel,
  output logic [2:0]            alu_op,
  output logic                  alu_b_sel,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  flags_en,
  output logic                  pc_en,
  output logic [1:0]            pc_sel,
  output logic                  mem_addr_sel,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  illegal,
  output logic [2:0]            state
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [3:0]            opcode;
  logic [2:0]            funct;
  logic                  taken;

  assign opcode   = ir_q[15:12];
  assign funct    = ir_q[2:0];
  assign rf_addr1 = ir_q[11:9];
  assign rf_addr2 = ir_q[8:6];
  assign imm      = {{(DATA_WIDTH-9){ir_q[8]}}, ir_q[8:0]};
  assign ir       = ir_q;
  assign state    = state_q;

  cond_eval u_cond_eval (
    .cond_i  (ir_q[11:9]),
    .flags_i (flags),
    .taken_o (taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    rf_wr_en     = 1'b0;
    rf_wr_sel    = WR_ALU;
    alu_op       = ALU_ADD;
    alu_b_sel    = 1'b0;
    flags_en     = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = PC_INC;
    mem_addr_sel = 1'b0;
    mem_wr_en    = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      ST_FETCH: state_d = ST_DECODE;

      ST_DECODE: begin
        // ir is not loaded until this edge, so the branch to MEM looks at instr
        ir_d    = instr;
        state_d = (instr[15:12] == OP_LOAD || instr[15:12] == OP_STOR) ? ST_MEM : ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_en   = 1'b1;
        case (opcode)
          OP_RTYPE: begin
            rf_wr_en = 1'b1;
            case (funct)
              F_ADD: begin alu_op = ALU_ADD; flags_en = 1'b1; end
              F_SUB: begin alu_op = ALU_SUB; flags_en = 1'b1; end
              F_AND: alu_op = ALU_AND;
              F_OR:  alu_op = ALU_OR;
              F_XOR: alu_op = ALU_XOR;
              F_CMP: begin alu_op = ALU_SUB; flags_en = 1'b1; rf_wr_en = 1'b0; end
              F_MOV: alu_op = ALU_MOVB;
              default: begin rf_wr_en = 1'b0; illegal = 1'b1; end
            endcase
          end
          OP_ADDI: begin
            alu_op = ALU_ADD; alu_b_sel = 1'b1; rf_wr_en = 1'b1; flags_en = 1'b1;
          end
          OP_SUBI: begin
            alu_op = ALU_SUB; alu_b_sel = 1'b1; rf_wr_en = 1'b1; flags_en = 1'b1;
          end
          OP_CMPI: begin
            alu_op = ALU_SUB; alu_b_sel = 1'b1; flags_en = 1'b1;
          end
          OP_MOVI: begin
            rf_wr_en = 1'b1; rf_wr_sel = WR_IMM;
          end
          OP_BCC:  pc_sel = taken ? PC_REL : PC_INC;
          OP_JAL: begin
            rf_wr_en = 1'b1; rf_wr_sel = WR_PC1; pc_sel = PC_REG;
          end
          default: illegal = 1'b1;
        endcase
      end

      ST_MEM: begin
        mem_addr_sel = 1'b1;
        if (opcode == OP_STOR) begin
          mem_wr_en = 1'b1;
          pc_en     = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          state_d   = ST_LDWB;
        end
      end

      ST_LDWB: begin
        rf_wr_en  = 1'b1;
        rf_wr_sel = WR_MEM;
        pc_en     = 1'b1;
        state_d   = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic [2:0]  flags;
  logic [2:0]  rf_addr1, rf_addr2, alu_op, state;
  logic        rf_wr_en, alu_b_sel, flags_en, pc_en, mem_addr_sel, mem_wr_en, illegal;
  logic [1:0]  rf_wr_sel, pc_sel;
  logic [15:0] imm, ir;

  control_fsm #(.DATA_WIDTH(16), .REG_ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .instr(instr), .flags(flags),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_wr_en(rf_wr_en),
    .rf_wr_sel(rf_wr_sel), .alu_op(alu_op), .alu_b_sel(alu_b_sel),
    .imm(imm), .flags_en(flags_en), .pc_en(pc_en), .pc_sel(pc_sel),
    .mem_addr_sel(mem_addr_sel), .mem_wr_en(mem_wr_en), .ir(ir),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Expected per-cycle snapshot of every DUT output
  typedef struct {
    logic [2:0]  st;
    logic [15:0] ir;
    logic [2:0]  a1, a2;
    logic        we;
    logic [1:0]  wsel;
    logic [2:0]  aop;
    logic        bsel;
    logic [15:0] imm;
    logic        fen, pen;
    logic [1:0]  psel;
    logic        masel, mwe, ill;
  } rec_t;

  rec_t        exp_q[$];
  logic [15:0] cur_ir;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, expv, $time);
    end
  endtask

  // Quiet snapshot: only the ir-derived fields are non-zero
  function automatic rec_t base(input logic [2:0] st, input logic [15:0] w);
    rec_t r;
    int   sx;
    sx = int'(w[8:0]) - (w[8] ? 512 : 0);
    r.st = st; r.ir = w; r.a1 = w[11:9]; r.a2 = w[8:6];
    r.imm = 16'(sx);
    r.we = 0; r.wsel = 0; r.aop = 0; r.bsel = 0; r.fen = 0; r.pen = 0;
    r.psel = 0; r.masel = 0; r.mwe = 0; r.ill = 0;
    return r;
  endfunction

  // Reference model: push the whole expected cycle sequence, then let it run
  task automatic issue(input logic [15:0] w, input logic [2:0] fl);
    rec_t       r;
    int         op, f, n;
    logic [7:0] tk;
    op = int'(w[15:12]);
    f  = int'(w[2:0]);
    instr = w;
    flags = fl;
    exp_q.push_back(base(3'd0, cur_ir));
    exp_q.push_back(base(3'd1, cur_ir));
    if (op == 5 || op == 6) begin
      r = base(3'd3, w);
      r.masel = 1;
      if (op == 6) begin r.mwe = 1; r.pen = 1; end
      exp_q.push_back(r);
      if (op == 5) begin
        r = base(3'd4, w);
        r.we = 1; r.wsel = 2'd1; r.pen = 1;
        exp_q.push_back(r);
      end
    end else begin
      r = base(3'd2, w);
      r.pen = 1;
      if (op > 8 || (op == 0 && f == 7)) begin
        r.ill = 1;
      end else if (op == 7) begin
        // {n,z,c} = fl; conditions EQ,NE,LT,GE,CS,CC,AL,NV indexed by cond
        tk = {1'b0, 1'b1, ~fl[0], fl[0], ~fl[2], fl[2], ~fl[1], fl[1]};
        r.psel = tk[w[11:9]] ? 2'd1 : 2'd0;
      end else if (op == 8) begin
        r.we = 1; r.wsel = 2'd3; r.psel = 2'd2;
      end else begin
        r.we   = !(op == 3 || (op == 0 && f == 5));
        r.fen  = (op >= 1 && op <= 3) || (op == 0 && (f == 0 || f == 1 || f == 5));
        r.bsel = (op >= 1 && op <= 3);
        r.wsel = (op == 4) ? 2'd2 : 2'd0;
        if (op == 0)      r.aop = (f == 5) ? 3'd1 : (f == 6) ? 3'd5 : 3'(f);
        else if (op == 4) r.aop = 3'd0;
        else              r.aop = (op == 1) ? 3'd0 : 3'd1;
      end
      exp_q.push_back(r);
    end
    cur_ir = w;
    n = exp_q.size();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: one snapshot compared per cycle, away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec_t e;
      e = exp_q.pop_front();
      chk("state", 16'(state), 16'(e.st));
      chk("ir", ir, e.ir);
      chk("rf_addr1", 16'(rf_addr1), 16'(e.a1));
      chk("rf_addr2", 16'(rf_addr2), 16'(e.a2));
      chk("rf_wr_en", 16'(rf_wr_en), 16'(e.we));
      chk("rf_wr_sel", 16'(rf_wr_sel), 16'(e.wsel));
      chk("alu_op", 16'(alu_op), 16'(e.aop));
      chk("alu_b_sel", 16'(alu_b_sel), 16'(e.bsel));
      chk("imm", imm, e.imm);
      chk("flags_en", 16'(flags_en), 16'(e.fen));
      chk("pc_en", 16'(pc_en), 16'(e.pen));
      chk("pc_sel", 16'(pc_sel), 16'(e.psel));
      chk("mem_addr_sel", 16'(mem_addr_sel), 16'(e.masel));
      chk("mem_wr_en", 16'(mem_wr_en), 16'(e.mwe));
      chk("illegal", 16'(illegal), 16'(e.ill));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w;
    logic [3:0]  op;
    reset  = 1'b1;
    instr  = '0;
    flags  = '0;
    cur_ir = '0;
    @(posedge clk); #1;
    // Reset state held for two sampled cycles
    exp_q.push_back(base(3'd0, 16'h0000));
    exp_q.push_back(base(3'd0, 16'h0000));
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;

    issue(16'h0A80, 3'b000);  // ADD r5,r2
    issue(16'h51C0, 3'b101);  // LOAD r0,[r7]
    issue(16'h6A40, 3'b000);  // STOR r5,[r1]
    issue(16'h71FC, 3'b010);  // BEQ -4, z=1
    issue(16'h71FC, 3'b000);  // BEQ -4, z=0
    issue(16'hF000, 3'b111);  // undefined opcode
    issue(16'h0007, 3'b000);  // undefined funct

    // Reset during EXEC of an ADD: abandon it, everything quiet
    instr = 16'h0A80;
    exp_q.push_back(base(3'd0, cur_ir));
    exp_q.push_back(base(3'd1, cur_ir));
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    exp_q.push_back(base(3'd0, 16'h0000));
    exp_q.push_back(base(3'd0, 16'h0000));
    repeat (2) begin @(posedge clk); #1; end
    reset  = 1'b0;
    cur_ir = '0;

    issue(16'h8E40, 3'b000);  // JAL r7,r1

    for (int i = 0; i < 300; i++) begin
      w  = 16'($urandom);
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      w[15:12] = op;
      issue(w, 3'($urandom_range(0, 7)));
    end

    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
